// File: rtl/mult_div_issue_queue.sv
// In-order issue queue feeding the multiply or divide unit; operands wake up from the CDB.
// Optional macro MULT_DIV_ISSUE_BYPASS_EN lets the head issue in the same cycle as its CDB wakeup.
module mult_div_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       dispatch_en,
    input  logic [DATA_W-1:0]          disp_rs1_data,
    input  logic [DATA_W-1:0]          disp_rs2_data,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic                       disp_rs1_valid,
    input  logic                       disp_rs2_valid,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       queue_full,
    output logic                       queue_empty,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [DATA_W-1:0]          issue_rs1_data,
    output logic [DATA_W-1:0]          issue_rs2_data,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] rs1_data_reg  [DEPTH];
    logic [DATA_W-1:0] rs2_data_reg  [DEPTH];
    logic [TAG_W-1:0]  rs1_tag_reg   [DEPTH];
    logic [TAG_W-1:0]  rs2_tag_reg   [DEPTH];
    logic              rs1_valid_reg [DEPTH];
    logic              rs2_valid_reg [DEPTH];
    logic [TAG_W-1:0]  rd_tag_reg    [DEPTH];
    logic              occ_reg       [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic clear;
    logic push;
    logic pop;
    logic disp_rs1_hit;
    logic disp_rs2_hit;
    logic head_rs1_hit;
    logic head_rs2_hit;

    assign clear       = rst | flush;
    assign queue_full  = (count_reg == CNT_W'(DEPTH));
    assign queue_empty = (count_reg == '0);
    assign count       = count_reg;
    assign push        = dispatch_en & ~queue_full;
    assign pop         = issue_valid & issue_ready;

    // An operand broadcast on the CDB while it is being dispatched must not be missed.
    assign disp_rs1_hit = ~disp_rs1_valid & cdb_valid & (cdb_tag == disp_rs1_tag);
    assign disp_rs2_hit = ~disp_rs2_valid & cdb_valid & (cdb_tag == disp_rs2_tag);

`ifdef MULT_DIV_ISSUE_BYPASS_EN
    assign head_rs1_hit = ~rs1_valid_reg[rd_ptr_reg] & cdb_valid & (cdb_tag == rs1_tag_reg[rd_ptr_reg]);
    assign head_rs2_hit = ~rs2_valid_reg[rd_ptr_reg] & cdb_valid & (cdb_tag == rs2_tag_reg[rd_ptr_reg]);
`else
    assign head_rs1_hit = 1'b0;
    assign head_rs2_hit = 1'b0;
`endif

    always_comb begin
        issue_valid    = occ_reg[rd_ptr_reg]
                       & (rs1_valid_reg[rd_ptr_reg] | head_rs1_hit)
                       & (rs2_valid_reg[rd_ptr_reg] | head_rs2_hit);
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_rd_tag   = '0;
        if (occ_reg[rd_ptr_reg]) begin
            issue_rs1_data = head_rs1_hit ? cdb_data : rs1_data_reg[rd_ptr_reg];
            issue_rs2_data = head_rs2_hit ? cdb_data : rs2_data_reg[rd_ptr_reg];
            issue_rd_tag   = rd_tag_reg[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Push and pop never target the same slot: a push needs a free slot, a pop an occupied one.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
            logic wr_sel;
            logic rd_sel;

            assign wr_sel = push & (wr_ptr_reg == IDX);
            assign rd_sel = pop & (rd_ptr_reg == IDX);

            always_ff @(posedge clk) begin
                if (clear) begin
                    occ_reg[gi]       <= 1'b0;
                    rs1_valid_reg[gi] <= 1'b0;
                    rs2_valid_reg[gi] <= 1'b0;
                end else if (wr_sel) begin
                    occ_reg[gi]       <= 1'b1;
                    rs1_tag_reg[gi]   <= disp_rs1_tag;
                    rs2_tag_reg[gi]   <= disp_rs2_tag;
                    rd_tag_reg[gi]    <= disp_rd_tag;
                    rs1_data_reg[gi]  <= disp_rs1_hit ? cdb_data : disp_rs1_data;
                    rs2_data_reg[gi]  <= disp_rs2_hit ? cdb_data : disp_rs2_data;
                    rs1_valid_reg[gi] <= disp_rs1_valid | disp_rs1_hit;
                    rs2_valid_reg[gi] <= disp_rs2_valid | disp_rs2_hit;
                end else begin
                    if (rd_sel) occ_reg[gi] <= 1'b0;
                    if (occ_reg[gi] && !rs1_valid_reg[gi] && cdb_valid && cdb_tag == rs1_tag_reg[gi]) begin
                        rs1_data_reg[gi]  <= cdb_data;
                        rs1_valid_reg[gi] <= 1'b1;
                    end
                    if (occ_reg[gi] && !rs2_valid_reg[gi] && cdb_valid && cdb_tag == rs2_tag_reg[gi]) begin
                        rs2_data_reg[gi]  <= cdb_data;
                        rs2_valid_reg[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_mult_div_issue_queue.sv
// Scoreboard bench for mult_div_issue_queue: expected issues are queued at dispatch and checked on pop.
module tb_mult_div_issue_queue;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [TAG_W-1:0]  rd;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              dispatch_en = 1'b0;
    logic [DATA_W-1:0] disp_rs1_data = '0;
    logic [DATA_W-1:0] disp_rs2_data = '0;
    logic [TAG_W-1:0]  disp_rs1_tag = '0;
    logic [TAG_W-1:0]  disp_rs2_tag = '0;
    logic              disp_rs1_valid = 1'b0;
    logic              disp_rs2_valid = 1'b0;
    logic [TAG_W-1:0]  disp_rd_tag = '0;
    logic              cdb_valid = 1'b0;
    logic [TAG_W-1:0]  cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic              queue_full;
    logic              queue_empty;
    logic              issue_valid;
    logic              issue_ready = 1'b0;
    logic [DATA_W-1:0] issue_rs1_data;
    logic [DATA_W-1:0] issue_rs2_data;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic [$clog2(DEPTH):0] count;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    mult_div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dispatch_en(dispatch_en),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs2_valid(disp_rs2_valid),
        .disp_rd_tag(disp_rd_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .queue_full(queue_full), .queue_empty(queue_empty),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", tag, got, $time);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                           input logic [TAG_W-1:0] t1, input logic [TAG_W-1:0] t2,
                           input logic v1, input logic v2, input logic [TAG_W-1:0] rd,
                           input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                           input bit accept);
        exp_t e;
        dispatch_en    = 1'b1;
        disp_rs1_data  = d1;
        disp_rs2_data  = d2;
        disp_rs1_tag   = t1;
        disp_rs2_tag   = t2;
        disp_rs1_valid = v1;
        disp_rs2_valid = v2;
        disp_rd_tag    = rd;
        if (accept) begin
            e.rd = rd; e.rs1 = e1; e.rs2 = e2;
            sb.push_back(e);
        end
        cycle(1);
        dispatch_en = 1'b0;
    endtask

    // Every accepted issue is compared against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_rd_tag", 64'(issue_rd_tag), 64'(e.rd));
                check("issue_rs1", 64'(issue_rs1_data), 64'(e.rs1));
                check("issue_rs2", 64'(issue_rs2_data), 64'(e.rs2));
            end
        end
    end

    initial begin
        int m_count;
        bit do_p;
        cycle(2);
        @(negedge clk);
        check("rst_empty", 64'(queue_empty), 64'd1);
        check("rst_full", 64'(queue_full), 64'd0);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rs1_data", 64'(issue_rs1_data), 64'd0);
        rst = 1'b0;
        cycle(1);

        // Single fully valid entry: issues one cycle after the push.
        issue_ready = 1'b1;
        do_push(32'd5, 32'd7, 6'd0, 6'd0, 1'b1, 1'b1, 6'd3, 32'd5, 32'd7, 1'b1);
        @(negedge clk);
        check("t1_issue_valid", 64'(issue_valid), 64'd1);
        cycle(1);
        @(negedge clk);
        check("t1_empty", 64'(queue_empty), 64'd1);
        check("t1_count", 64'(count), 64'd0);

        // Fill to full, ignored fifth push, in-order drain.
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            do_push(32'(100 + i), 32'(200 + i), 6'd0, 6'd0, 1'b1, 1'b1, 6'(10 + i),
                    32'(100 + i), 32'(200 + i), 1'b1);
        @(negedge clk);
        check("t2_full", 64'(queue_full), 64'd1);
        check("t2_count", 64'(count), 64'd4);
        do_push(32'd999, 32'd999, 6'd0, 6'd0, 1'b1, 1'b1, 6'd14, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        check("t2_count_after_5th", 64'(count), 64'd4);
        issue_ready = 1'b1;
        cycle(DEPTH);
        @(negedge clk);
        check("t2_drained", 64'(queue_empty), 64'd1);

        // Head waits on tag 9 and blocks a ready younger entry.
        do_push(32'h11, 32'h0, 6'd0, 6'd9, 1'b1, 1'b0, 6'd20, 32'h11, 32'h1234, 1'b1);
        do_push(32'h21, 32'h22, 6'd0, 6'd0, 1'b1, 1'b1, 6'd21, 32'h21, 32'h22, 1'b1);
        @(negedge clk);
        check("t3_blocked", 64'(issue_valid), 64'd0);
        check("t3_count", 64'(count), 64'd2);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h1234;
        cycle(1);
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t3_issue_valid", 64'(issue_valid), 64'd1);
`ifdef MULT_DIV_ISSUE_BYPASS_EN
        check("t3_count_after_wake", 64'(count), 64'd1);
`else
        check("t3_count_after_wake", 64'(count), 64'd2);
`endif
        cycle(3);
        @(negedge clk);
        check("t3_empty", 64'(queue_empty), 64'd1);

        // Same-cycle CDB capture at dispatch.
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hAA;
        do_push(32'hDEAD, 32'h3, 6'd12, 6'd0, 1'b0, 1'b1, 6'd22, 32'hAA, 32'h3, 1'b1);
        cdb_valid = 1'b0;
        @(negedge clk);
        check("t4_issue_valid", 64'(issue_valid), 64'd1);
        cycle(1);

        // Flush, then reset, each racing a push.
        issue_ready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++)
                do_push(32'(i), 32'(i), 6'd0, 6'd0, 1'b1, 1'b1, 6'(30 + i), 32'(i), 32'(i), 1'b1);
            if (r == 0) flush = 1'b1; else rst = 1'b1;
            do_push(32'h77, 32'h77, 6'd0, 6'd0, 1'b1, 1'b1, 6'd33, 32'h0, 32'h0, 1'b0);
            flush = 1'b0;
            rst = 1'b0;
            sb.delete();
            @(negedge clk);
            check(r == 0 ? "t5_flush_count" : "t5_rst_count", 64'(count), 64'd0);
            check(r == 0 ? "t5_flush_empty" : "t5_rst_empty", 64'(queue_empty), 64'd1);
            check(r == 0 ? "t5_flush_iv" : "t5_rst_iv", 64'(issue_valid), 64'd0);
            cycle(1);
        end

        // Wakeup-to-issue latency on tag 4.
        issue_ready = 1'b1;
        do_push(32'h0, 32'h66, 6'd4, 6'd0, 1'b0, 1'b1, 6'd23, 32'h55, 32'h66, 1'b1);
        @(negedge clk);
        check("t6_waiting", 64'(issue_valid), 64'd0);
        cycle(1);
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h55;
        @(negedge clk);
`ifdef MULT_DIV_ISSUE_BYPASS_EN
        check("t6_wake_cycle_iv", 64'(issue_valid), 64'd1);
`else
        check("t6_wake_cycle_iv", 64'(issue_valid), 64'd0);
`endif
        cycle(1);
        cdb_valid = 1'b0;
        @(negedge clk);
`ifdef MULT_DIV_ISSUE_BYPASS_EN
        check("t6_next_cycle_iv", 64'(issue_valid), 64'd0);
`else
        check("t6_next_cycle_iv", 64'(issue_valid), 64'd1);
`endif
        cycle(1);

        // Random mix of pushes and pops with fully valid operands.
        m_count = 0;
        for (int i = 0; i < 60; i++) begin
            issue_ready = 1'($urandom_range(0, 1));
            do_p = 1'($urandom_range(0, 1));
            dispatch_en    = do_p;
            disp_rs1_data  = $urandom;
            disp_rs2_data  = $urandom;
            disp_rs1_valid = 1'b1;
            disp_rs2_valid = 1'b1;
            disp_rd_tag    = 6'($urandom_range(0, 63));
            if (do_p && m_count < DEPTH) begin
                exp_t e;
                e.rd = disp_rd_tag; e.rs1 = disp_rs1_data; e.rs2 = disp_rs2_data;
                sb.push_back(e);
            end
            @(negedge clk);
            check("rnd_count", 64'(count), 64'(m_count));
            check("rnd_issue_valid", 64'(issue_valid), 64'(m_count != 0));
            m_count = m_count + ((do_p && m_count < DEPTH) ? 1 : 0)
                              - ((issue_ready && m_count != 0) ? 1 : 0);
            cycle(1);
        end
        dispatch_en = 1'b0;
        issue_ready = 1'b1;
        cycle(DEPTH + 1);
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("final_empty", 64'(queue_empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
